lbus_uart_master: RTL
=====================

// Module: lbus_uart_master
// PURPOSE
//  Local-bus initiator driven by a UART byte stream: debug/boot loader path into the SoC bus.
//  Parses command frames from the RX byte interface and issues single-word local-bus writes/reads.
//  Returns acknowledge/read-data bytes on the TX byte interface. Sits between the UART byte engine and the bus fabric.
//  It is the initiator for the same waddr/wen/wready/raddr/ren/rvalid bus that uart_ip answers as a responder.
// PARAMETERS
//  ADDR_W       32           bus address width; multiple of 8
//  DATA_W       32           bus data width; multiple of 8
//  STRB_W       DATA_W/8     byte-strobe width
//  TIMEOUT_CYC  1024         bus wait limit in clk cycles (used only with LBUS_MASTER_TIMEOUT_EN)
// PORTS
//  clk       in   1       system clock
//  rst       in   1       synchronous reset, active-high
//  rx_data   in   8       received byte
//  rx_valid  in   1       1-cycle strobe: rx_data valid (no backpressure)
//  tx_data   out  8       byte to transmit
//  tx_valid  out  1       tx_data valid; held until tx_ready
//  tx_ready  in   1       TX engine accepts byte when tx_valid & tx_ready
//  waddr     out  ADDR_W  write address
//  wdata     out  DATA_W  write data
//  wen       out  1       write request
//  wstrb     out  STRB_W  write byte strobes
//  wready    in   1       write accepted
//  raddr     out  ADDR_W  read address
//  ren       out  1       read request
//  rdata     in   DATA_W  read data, valid with rvalid
//  rvalid    in   1       read data valid
//  busy      out  1       high whenever FSM is not in IDLE
//  overrun   out  1       1-cycle pulse: rx byte dropped
// BEHAVIOUR
//  Reset (sync, rst=1 at posedge): all outputs 0, FSM->IDLE, counters cleared; aborts any frame or bus access mid-flight.
//  Frames (multi-byte fields MSB first): 'W'(0x57) + ADDR_W/8 addr + DATA_W/8 data; 'R'(0x52) + ADDR_W/8 addr.
//  States: IDLE, ADDR, DATA, WR, RD, RESP.
//   IDLE: rx 0x57/0x52 -> latch cmd, ADDR, byte cnt=0; any other byte -> RESP with 0x3F ('?').
//   ADDR: shift byte into addr reg per rx_valid; after last addr byte -> DATA (W) or RD (R).
//   DATA: shift data bytes; after last -> WR.
//   WR: waddr/wdata driven, wstrb=all ones, wen=1; held until cycle with wen&wready; next cycle wen=0 -> RESP 0x4B ('K').
//   RD: raddr driven, ren=1 held until rvalid=1; rdata captured that cycle; ren=0 next cycle -> RESP 4-byte data MSB first.
//   RESP: tx_valid=1 with tx_data stable until tx_valid&tx_ready; next byte presented next cycle; after last -> IDLE.
//  Latency: bus request asserted 1 cycle after last frame byte; first response byte 1 cycle after bus completion.
//  rx_valid in WR/RD/RESP: byte dropped, overrun pulses 1 cycle; FSM unaffected.
//  wready/rvalid while no request outstanding: ignored. rvalid same cycle as ren rise: accepted.
//  waddr/raddr/wdata hold last value after access (not cleared) until next frame.
//  Byte counter 0..max(ADDR_W,DATA_W)/8-1, reset on every state entry; never wraps.
// CONFIGURATION
//  LBUS_MASTER_TIMEOUT_EN defined: wait counter runs in WR/RD; if wready/rvalid not seen within TIMEOUT_CYC
//   cycles of request assertion, request drops next cycle, response is single byte 0x54 ('T'), no read data.
//  Undefined: no counter; WR/RD wait indefinitely (only rst exits).
// TESTING
//  rx 57 00 00 00 10 DE AD BE EF, wready after 3 cycles -> waddr=0x10 wdata=0xDEADBEEF wstrb=F, wen 4 cycles, tx 4B.
//  rx 52 00 00 00 14, rvalid+rdata=0x12345678 2 cycles after ren -> tx 12 34 56 78 in order, then busy=0.
//  rx 41 -> tx 3F, no wen/ren; tx_ready low 5 cycles -> tx_valid/tx_data=3F stable throughout.
//  rx byte during WR wait -> overrun 1-cycle pulse, write completes normally, tx 4B.
//  rst after 2 addr bytes of 'R' frame -> outputs 0, IDLE; following 'W' frame completes correctly.
//  With LBUS_MASTER_TIMEOUT_EN, wready never -> wen drops after 1024 cycles, tx 54; without macro wen stays high.

Source files
------------

// File: rtl/lbus_uart_master.sv
// lbus_uart_master
//   Local-bus initiator fed by a UART byte stream (debug / boot-loader path).
//   Parses 'W' (0x57) + addr + data and 'R' (0x52) + addr frames, MSB first.
//   It then issues one single-word bus write or read. The result goes back
//   on the TX byte interface:
//     0x4B ('K')        write done
//     read data         read done, MSB first
//     0x3F ('?')        unknown command byte
//     0x54 ('T')        bus timeout
//
// Ports
//   clk, rst                  clock, synchronous active-high reset
//   rx_data, rx_valid         received byte stream (no backpressure)
//   tx_data, tx_valid,
//   tx_ready                  response byte stream (valid/ready)
//   waddr, wdata, wstrb,
//   wen, wready               bus write request / accept
//   raddr, ren, rdata,
//   rvalid                    bus read request / data return
//   busy                      FSM not idle
//   overrun                   1-cycle pulse when a received byte is dropped
//
// Configuration
//   LBUS_MASTER_TIMEOUT_EN    when defined, a bus access that sees no
//                             wready/rvalid within TIMEOUT_CYC cycles is
//                             abandoned and answered with 'T'.
module lbus_uart_master #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int STRB_W      = DATA_W / 8,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic [ADDR_W-1:0] waddr,
    output logic [DATA_W-1:0] wdata,
    output logic              wen,
    output logic [STRB_W-1:0] wstrb,
    input  logic              wready,
    output logic [ADDR_W-1:0] raddr,
    output logic              ren,
    input  logic [DATA_W-1:0] rdata,
    input  logic              rvalid,
    output logic              busy,
    output logic              overrun
);

    localparam int ADDR_B = ADDR_W / 8;
    localparam int DATA_B = DATA_W / 8;
    localparam int MAX_B  = (ADDR_B > DATA_B) ? ADDR_B : DATA_B;
    localparam int CNT_W  = (MAX_B > 1) ? $clog2(MAX_B) : 1;

    localparam logic [7:0] CMD_WR  = 8'h57;
    localparam logic [7:0] CMD_RD  = 8'h52;
    localparam logic [7:0] RSP_BAD = 8'h3F;
    localparam logic [7:0] RSP_OK  = 8'h4B;

`ifdef LBUS_MASTER_TIMEOUT_EN
    localparam logic [7:0] RSP_TO  = 8'h54;
    localparam int         TW      = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    logic [TW-1:0]         wait_cnt;
    logic                  timed_out;
    assign timed_out = (wait_cnt == TW'(TIMEOUT_CYC - 1));
`endif

    typedef enum logic [2:0] {IDLE, ADDR, DATA, WR, RD, RESP} state_t;

    state_t            state;
    logic              is_write;
    logic [CNT_W-1:0]  cnt;        // byte index within the current state
    logic [CNT_W-1:0]  resp_last;  // index of the final response byte
    logic [ADDR_W-1:0] addr_sr;
    // Collects write data while a frame arrives.
    // Reused to shift out read data while responding.
    logic [DATA_W-1:0] data_sr;

    logic [ADDR_W-1:0] addr_next;
    logic [DATA_W-1:0] data_next;
    logic [DATA_W-1:0] data_shl;

    assign addr_next = (addr_sr << 8) | ADDR_W'(rx_data);
    assign data_next = (data_sr << 8) | DATA_W'(rx_data);
    assign data_shl  = data_sr << 8;

    assign busy = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            is_write  <= 1'b0;
            cnt       <= '0;
            resp_last <= '0;
            addr_sr   <= '0;
            data_sr   <= '0;
            tx_data   <= '0;
            tx_valid  <= 1'b0;
            waddr     <= '0;
            wdata     <= '0;
            wstrb     <= '0;
            wen       <= 1'b0;
            raddr     <= '0;
            ren       <= 1'b0;
            overrun   <= 1'b0;
`ifdef LBUS_MASTER_TIMEOUT_EN
            wait_cnt  <= '0;
`endif
        end else begin
            overrun <= 1'b0;
`ifdef LBUS_MASTER_TIMEOUT_EN
            // Held at zero outside WR/RD so every access starts a fresh count.
            wait_cnt <= '0;
`endif
            case (state)
                IDLE: begin
                    if (rx_valid) begin
                        cnt <= '0;
                        if (rx_data == CMD_WR || rx_data == CMD_RD) begin
                            is_write <= (rx_data == CMD_WR);
                            state    <= ADDR;
                        end else begin
                            tx_data   <= RSP_BAD;
                            tx_valid  <= 1'b1;
                            resp_last <= '0;
                            state     <= RESP;
                        end
                    end
                end

                ADDR: begin
                    if (rx_valid) begin
                        addr_sr <= addr_next;
                        if (cnt == CNT_W'(ADDR_B - 1)) begin
                            cnt <= '0;
                            if (is_write) begin
                                state <= DATA;
                            end else begin
                                raddr <= addr_next;
                                ren   <= 1'b1;
                                state <= RD;
                            end
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end

                DATA: begin
                    if (rx_valid) begin
                        data_sr <= data_next;
                        if (cnt == CNT_W'(DATA_B - 1)) begin
                            cnt   <= '0;
                            waddr <= addr_sr;
                            wdata <= data_next;
                            wstrb <= '1;
                            wen   <= 1'b1;
                            state <= WR;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end

                // wen is high for the whole of WR, so wready alone marks the handshake.
                WR: begin
                    if (rx_valid) overrun <= 1'b1;
                    if (wready) begin
                        wen       <= 1'b0;
                        tx_data   <= RSP_OK;
                        tx_valid  <= 1'b1;
                        resp_last <= '0;
                        cnt       <= '0;
                        state     <= RESP;
                    end
`ifdef LBUS_MASTER_TIMEOUT_EN
                    else if (timed_out) begin
                        wen       <= 1'b0;
                        tx_data   <= RSP_TO;
                        tx_valid  <= 1'b1;
                        resp_last <= '0;
                        cnt       <= '0;
                        state     <= RESP;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
`endif
                end

                // ren is high for the whole of RD, so rvalid may land the cycle ren rises.
                RD: begin
                    if (rx_valid) overrun <= 1'b1;
                    if (rvalid) begin
                        ren       <= 1'b0;
                        data_sr   <= rdata;
                        tx_data   <= rdata[DATA_W-1 -: 8];
                        tx_valid  <= 1'b1;
                        resp_last <= CNT_W'(DATA_B - 1);
                        cnt       <= '0;
                        state     <= RESP;
                    end
`ifdef LBUS_MASTER_TIMEOUT_EN
                    else if (timed_out) begin
                        ren       <= 1'b0;
                        tx_data   <= RSP_TO;
                        tx_valid  <= 1'b1;
                        resp_last <= '0;
                        cnt       <= '0;
                        state     <= RESP;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
`endif
                end

                RESP: begin
                    if (rx_valid) overrun <= 1'b1;
                    if (tx_ready) begin
                        if (cnt == resp_last) begin
                            tx_valid <= 1'b0;
                            cnt      <= '0;
                            state    <= IDLE;
                        end else begin
                            cnt     <= cnt + 1'b1;
                            data_sr <= data_shl;
                            tx_data <= data_shl[DATA_W-1 -: 8];
                        end
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule
